// File: rtl/alu_result_buffer_if.sv
// Bundles the ALU-side push and write-back-side pop signals of the result buffer.
// Pure wiring: no storage and no added latency.
// Backpressure runs through in_ready toward the ALU and out_ready from write-back.
interface alu_result_buffer_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 4,
    parameter int REG_ADDR_WIDTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     in_result;
    logic [3:0]                in_opcode;
    logic [REG_ADDR_WIDTH-1:0] in_dest;

    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_result;
    logic [REG_ADDR_WIDTH-1:0] out_dest;
    logic                      out_zero;
    logic                      out_neg;

    logic [CNT_W-1:0]          count;
    logic                      err_illegal_op;

    // Environment side: drives ALU results in and write-back ready.
    modport master (
        output in_valid, in_result, in_opcode, in_dest, out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_zero, out_neg,
        input  count, err_illegal_op
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_result, in_opcode, in_dest, out_ready,
        output in_ready, out_valid, out_result, out_dest, out_zero, out_neg,
        output count, err_illegal_op
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Buffers ALU results with destination index and zero/neg flags for register write-back.
// Latency: an entry pushed into an empty buffer is on out_* the next cycle; no bypass.
// Backpressure: in_ready = not full, out_valid = not empty, both from registered count.
module alu_result_buffer #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 4,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic               clock,
    input  logic               clear,
    alu_result_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      zero;
        logic                      neg;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic   op_legal;
    logic   push_hs;
    logic   push_wr;
    logic   pop;
    entry_t wr_entry;
    entry_t head;

    // Only AND/OR/NOT/NEG (opcodes 0..3) produce a write-back entry.
    assign op_legal = (bus.in_opcode[3:2] == 2'b00);
    assign push_hs  = bus.in_valid && bus.in_ready;
    assign push_wr  = push_hs && op_legal;
    assign pop      = bus.out_valid && bus.out_ready;

    // Flags are captured with the result so write-back never recomputes them.
    assign wr_entry.result = bus.in_result;
    assign wr_entry.dest   = bus.in_dest;
    assign wr_entry.zero   = (bus.in_result == '0);
    assign wr_entry.neg    = bus.in_result[DATA_WIDTH-1];

    // Pointer, occupancy and sticky-error next state from the push/pop decisions.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (push_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_wr, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (push_hs && !op_legal) begin
            err_d = 1'b1;
        end
    end

    // Control state register; clear overrides any same-cycle push or pop.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Entry storage is deliberately not reset; occupancy alone says what is live.
    always_ff @(posedge clock) begin
        if (!clear && push_wr) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.in_ready       = (cnt_q != FULL_CNT);
    assign bus.out_valid      = (cnt_q != '0);
    assign bus.out_result     = head.result;
    assign bus.out_dest       = head.dest;
    assign bus.out_zero       = head.zero;
    assign bus.out_neg        = head.neg;
    assign bus.count          = cnt_q;
    assign bus.err_illegal_op = err_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized and directed bench for alu_result_buffer with a queue-based scoreboard.
// Stimulus changes 1 time unit after the rising edge; the monitor samples on the falling edge.
// Expected entries are queued by the driver when a push is accepted and popped by the monitor.
module tb_alu_result_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 4;

    typedef struct {
        logic [DW-1:0] result;
        logic [AW-1:0] dest;
        logic          zero;
        logic          neg;
    } exp_t;

    logic clock;
    logic clear;

    alu_result_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .REG_ADDR_WIDTH(AW)) bus ();

    alu_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .REG_ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    exp_t exp_q[$];
    logic exp_err;
    bit   mon_en;
    int   checks;
    int   errors;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [DW-1:0] r, input logic [AW-1:0] d);
        exp_t e;
        e.result = r;
        e.dest   = d;
        e.zero   = (r == 0);
        e.neg    = (r >= 8'h80);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: status against the model every cycle, head entry whenever valid.
    always @(negedge clock) begin
        if (mon_en) begin
            check("count", 32'(bus.count), 32'(exp_q.size()));
            check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
            check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
            check("err_illegal_op", 32'(bus.err_illegal_op), 32'(exp_err));
            if (bus.out_valid && exp_q.size() > 0) begin
                check("out_result", 32'(bus.out_result), 32'(exp_q[0].result));
                check("out_dest", 32'(bus.out_dest), 32'(exp_q[0].dest));
                check("out_zero", 32'(bus.out_zero), 32'(exp_q[0].zero));
                check("out_neg", 32'(bus.out_neg), 32'(exp_q[0].neg));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; called 1 unit after a rising edge and returns likewise.
    // The accept decision is recorded after the monitor has sampled the falling edge.
    task automatic cyc(input logic v, input logic [DW-1:0] r, input logic [3:0] op,
                       input logic [AW-1:0] d, input logic rdy, input logic clr);
        bus.in_valid  = v;
        bus.in_result = r;
        bus.in_opcode = op;
        bus.in_dest   = d;
        bus.out_ready = rdy;
        clear         = clr;
        @(negedge clock);
        #1;
        if (clr) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else if (v && bus.in_ready) begin
            if (op < 4'd4) exp_q.push_back(mk(r, d));
            else           exp_err = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 8'h00, 4'h0, 4'h0, rdy, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] r;
        checks  = 0;
        errors  = 0;
        exp_err = 1'b0;
        mon_en  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_opcode = '0;
        bus.in_dest   = '0;
        bus.out_ready = 1'b0;
        clear         = 1'b1;
        @(posedge clock);
        #1;
        cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1);
        mon_en = 1'b1;

        // Reset state and basic push
        check("rst_count", 32'(bus.count), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_err", 32'(bus.err_illegal_op), 0);
        cyc(1'b1, 8'h0F, 4'b0000, 4'd3, 1'b0, 1'b0);
        check("basic_valid", 32'(bus.out_valid), 1);
        check("basic_result", 32'(bus.out_result), 32'h0F);
        check("basic_dest", 32'(bus.out_dest), 3);
        check("basic_count", 32'(bus.count), 1);
        idle(1'b1);

        // Flags
        cyc(1'b1, 8'h00, 4'b0001, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 8'hF1, 4'b0011, 4'd2, 1'b0, 1'b0);
        check("flag_zero_head", 32'(bus.out_zero), 1);
        check("flag_neg_head", 32'(bus.out_neg), 0);
        idle(1'b1);
        check("flag_zero_second", 32'(bus.out_zero), 0);
        check("flag_neg_second", 32'(bus.out_neg), 1);
        idle(1'b1);

        // Full and backpressure: 5 pushes, only 4 fit
        for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 4'b0001, 4'(i), 1'b0, 1'b0);
        check("full_count", 32'(bus.count), DEPTH);
        check("full_in_ready", 32'(bus.in_ready), 0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("drain_count", 32'(bus.count), 0);

        // Push + pop while full: pop only, then the held push lands
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h10 + 8'(i), 4'b0000, 4'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h80, 4'b0010, 4'd9, 1'b1, 1'b0);
        check("full_pop_only", 32'(bus.count), 3);
        cyc(1'b1, 8'h80, 4'b0010, 4'd9, 1'b0, 1'b0);
        check("full_refill", 32'(bus.count), 4);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Illegal opcode: handshake completes, nothing stored, sticky error
        cyc(1'b1, 8'h55, 4'b0000, 4'd5, 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 4'b0111, 4'd6, 1'b1, 1'b0);
        check("illegal_count", 32'(bus.count), 0);
        check("illegal_err", 32'(bus.err_illegal_op), 1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h20 + 8'(i), 4'(i), 4'(i), 1'b1, 1'b0);
        check("illegal_sticky", 32'(bus.err_illegal_op), 1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Wrap-around: 10 random entries with random write-back stalls
        for (int n = 0; n < 10; ) begin
            r = 8'($urandom);
            if (bus.in_ready) n++;
            cyc(1'b1, r, 4'($urandom_range(0, 3)), 4'($urandom), 1'($urandom), 1'b0);
        end
        for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);

        // Clear mid-stream with count=2, alongside a push and a pop
        cyc(1'b1, 8'hC1, 4'b0000, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 8'hC2, 4'b0000, 4'd2, 1'b0, 1'b0);
        check("pre_clear_count", 32'(bus.count), 2);
        cyc(1'b1, 8'hC3, 4'b0000, 4'd3, 1'b1, 1'b1);
        check("clear_count", 32'(bus.count), 0);
        check("clear_valid", 32'(bus.out_valid), 0);
        check("clear_err", 32'(bus.err_illegal_op), 0);
        cyc(1'b1, 8'h3C, 4'b0001, 4'd7, 1'b0, 1'b0);
        check("post_clear_head", 32'(bus.out_result), 32'h3C);
        idle(1'b1);

        // Long random run, occasional illegal opcodes and clears
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom),
                ($urandom_range(0, 15) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
                4'($urandom), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
